// File: rtl/anneal_ctrl_if.sv
// Neuron-side handshake bundle: load strobes and done flags, network phase
// handshake and the scheduled mu value presented to the neuron.
interface anneal_ctrl_if #(
  parameter int FP_DATA_WIDTH = 16
) ();
  logic                     en_neuron;
  logic                     wrQ;
  logic                     wrVmem;
  logic                     wrNeuronI;
  logic                     wrMu;
  logic                     en_spike;
  logic [FP_DATA_WIDTH-1:0] mu_sched;
  logic                     neuronWrQDone;
  logic                     neuronWrVmemDone;
  logic                     neuronWrNeuronIDone;
  logic                     neuronWrMuDone;
  logic                     en_network;
  logic                     networkDone;

  modport master (
    output en_neuron, wrQ, wrVmem, wrNeuronI, wrMu, en_spike, mu_sched,
    input  neuronWrQDone, neuronWrVmemDone, neuronWrNeuronIDone, neuronWrMuDone,
    input  en_network, networkDone
  );

  modport slave (
    input  en_neuron, wrQ, wrVmem, wrNeuronI, wrMu, en_spike, mu_sched,
    output neuronWrQDone, neuronWrVmemDone, neuronWrNeuronIDone, neuronWrMuDone,
    output en_network, networkDone
  );
endinterface

// File: rtl/anneal_ctrl.sv
// Anneal controller: sequences the four neuron load handshakes, then runs the
// spike/network iterations while stepping mu through a 16-entry schedule table.
module anneal_ctrl #(
  parameter int FP_DATA_WIDTH = 16,
  parameter int ITER_WIDTH    = 16,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ITER_WIDTH-1:0]    num_iter,
  input  logic [7:0]               steps_per_mu,
  input  logic                     sched_we,
  input  logic [3:0]               sched_addr,
  input  logic [FP_DATA_WIDTH-1:0] sched_data,
  anneal_ctrl_if.master            nrn,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [ITER_WIDTH-1:0]    iter_count,
  output logic [3:0]               sched_idx
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, LD_Q, LD_VMEM, LD_NID, LD_MU, SPIKE, RUN, FINISH, ERR
  } state_e;

  state_e                   state_q;
  logic [WAIT_W-1:0]        wait_q;
  logic [ITER_WIDTH-1:0]    iter_q;
  logic [3:0]               idx_q;
  logic [7:0]               sub_q;
  logic                     wrq_q, wrvmem_q, wrnid_q, wrmu_q, en_spike_q, en_neuron_q;
  logic                     busy_q, done_q, terr_q;
  logic [FP_DATA_WIDTH-1:0] sched_tbl_q [16];

  logic                     ld_done_d;
  state_e                   ld_next_d;
  logic                     ld_ready_d;
  logic                     ld_tmo_d;
  logic [7:0]               spm_eff_d;
  logic [8:0]               sub_nxt_d;
  logic                     step_done_d;
  logic [ITER_WIDTH-1:0]    iter_nxt_d;

  // Done flag and successor of the load state currently being served.
  always_comb begin
    ld_done_d = 1'b0;
    ld_next_d = IDLE;
    case (state_q)
      LD_Q:    begin ld_done_d = nrn.neuronWrQDone;       ld_next_d = LD_VMEM; end
      LD_VMEM: begin ld_done_d = nrn.neuronWrVmemDone;    ld_next_d = LD_NID;  end
      LD_NID:  begin ld_done_d = nrn.neuronWrNeuronIDone; ld_next_d = LD_MU;   end
      LD_MU:   begin ld_done_d = nrn.neuronWrMuDone;      ld_next_d = SPIKE;   end
      default: begin ld_done_d = 1'b0;                    ld_next_d = IDLE;    end
    endcase
  end

  // wait_q is 0 in the strobe cycle, so >=2 means two full cycles have elapsed.
  assign ld_ready_d  = ld_done_d && (wait_q >= WAIT_W'(2));
  assign ld_tmo_d    = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign spm_eff_d   = (steps_per_mu == 8'd0) ? 8'd1 : steps_per_mu;
  assign sub_nxt_d   = {1'b0, sub_q} + 9'd1;
  assign step_done_d = (sub_nxt_d >= {1'b0, spm_eff_d});
  assign iter_nxt_d  = iter_q + ITER_WIDTH'(1);

  // Control FSM with all status and strobe outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      iter_q      <= '0;
      idx_q       <= 4'd0;
      sub_q       <= 8'd0;
      wrq_q       <= 1'b0;
      wrvmem_q    <= 1'b0;
      wrnid_q     <= 1'b0;
      wrmu_q      <= 1'b0;
      en_spike_q  <= 1'b0;
      en_neuron_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      wrq_q      <= 1'b0;
      wrvmem_q   <= 1'b0;
      wrnid_q    <= 1'b0;
      wrmu_q     <= 1'b0;
      en_spike_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= LD_Q;
            wrq_q       <= 1'b1;
            wait_q      <= '0;
            en_neuron_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
            iter_q      <= '0;
            idx_q       <= 4'd0;
            sub_q       <= 8'd0;
          end
        end
        LD_Q, LD_VMEM, LD_NID, LD_MU: begin
          if (ld_ready_d) begin
            state_q  <= ld_next_d;
            wait_q   <= '0;
            wrvmem_q <= (state_q == LD_Q);
            wrnid_q  <= (state_q == LD_VMEM);
            wrmu_q   <= (state_q == LD_NID);
          end else if (ld_tmo_d) begin
            state_q     <= ERR;
            wait_q      <= '0;
            en_neuron_q <= 1'b0;
            done_q      <= 1'b1;
            terr_q      <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        SPIKE: begin
          if (num_iter == '0) begin
            state_q     <= FINISH;
            en_neuron_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            state_q    <= RUN;
            en_spike_q <= 1'b1;
          end
        end
        RUN: begin
          if (nrn.en_network && nrn.networkDone) begin
            iter_q <= iter_nxt_d;
            if (step_done_d) begin
              sub_q <= 8'd0;
              idx_q <= (idx_q == 4'd15) ? 4'd15 : idx_q + 4'd1;
            end else begin
              sub_q <= sub_nxt_d[7:0];
            end
            if (iter_nxt_d == num_iter) begin
              state_q     <= FINISH;
              en_neuron_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        FINISH: state_q <= IDLE;
        ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Schedule table has no reset so its contents survive between runs.
  always_ff @(posedge clk) begin
    if (sched_we && !busy_q) begin
      sched_tbl_q[sched_addr] <= sched_data;
    end
  end

  assign nrn.wrQ       = wrq_q;
  assign nrn.wrVmem    = wrvmem_q;
  assign nrn.wrNeuronI = wrnid_q;
  assign nrn.wrMu      = wrmu_q;
  assign nrn.en_spike  = en_spike_q;
  assign nrn.en_neuron = en_neuron_q;
  assign nrn.mu_sched  = sched_tbl_q[idx_q];
  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout_err   = terr_q;
  assign iter_count    = iter_q;
  assign sched_idx     = idx_q;

endmodule

// File: tb/tb_anneal_ctrl.sv
// Directed and randomized bench for anneal_ctrl with a behavioural neuron and
// a schedule reference model (mu index = min(k / max(steps,1), 15)).
module tb_anneal_ctrl;
  localparam int TMO = 32;

  logic        clk = 1'b0;
  logic        reset, start, sched_we;
  logic [15:0] num_iter, sched_data, iter_count;
  logic [7:0]  steps_per_mu;
  logic [3:0]  sched_addr, sched_idx;
  logic        busy, done, timeout_err;

  anneal_ctrl_if #(.FP_DATA_WIDTH(16)) nif ();

  anneal_ctrl #(.FP_DATA_WIDTH(16), .ITER_WIDTH(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .num_iter(num_iter),
    .steps_per_mu(steps_per_mu), .sched_we(sched_we), .sched_addr(sched_addr),
    .sched_data(sched_data), .nrn(nif), .busy(busy), .done(done),
    .timeout_err(timeout_err), .iter_count(iter_count), .sched_idx(sched_idx)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [15:0] tbl_m [16];
  int ld_cnt [4];
  bit ld_flag [4];
  bit hold_vmem_low = 1'b0;
  bit in_run = 1'b0, en_net = 1'b0, net_done_drv = 1'b0;
  bit spur_pending = 1'b0, spur_active = 1'b0;
  int net_cnt = 0, overlap = 0, spikes = 0, accepted = 0;
  logic fin_en, fin_done;
  int strobe_log [$];
  logic [15:0] mu_log [$], it_log [$];
  logic [3:0] idx_log [$];
  logic [15:0] exp33 [5] = '{16'h3C00, 16'h3800, 16'h3800, 16'h3400, 16'h3400};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, then advance the neuron model.
  task automatic tick();
    logic [3:0] s;
    @(posedge clk); #1;
    cyc++;
    s = {nif.wrMu, nif.wrNeuronI, nif.wrVmem, nif.wrQ};
    if ($countones(s) > 1) overlap++;
    for (int i = 0; i < 4; i++) begin
      if (s[i] === 1'b1) begin
        strobe_log.push_back(i); ld_cnt[i] = 3; ld_flag[i] = 1'b0;
      end else if (ld_cnt[i] != 0) begin
        ld_cnt[i]--;
        if (ld_cnt[i] == 0 && !(i == 1 && hold_vmem_low)) ld_flag[i] = 1'b1;
      end
    end
    if (nif.en_spike === 1'b1) begin spikes++; in_run = 1'b1; end
    if (nif.en_neuron !== 1'b1) in_run = 1'b0;
    spur_active = 1'b0;
    if (net_done_drv) begin
      accepted++;
      mu_log.push_back(nif.mu_sched); idx_log.push_back(sched_idx); it_log.push_back(iter_count);
      fin_en = nif.en_neuron; fin_done = done;
      net_done_drv = 1'b0; en_net = 1'b0;
    end else if (en_net) begin
      if (net_cnt > 1) net_cnt--; else net_done_drv = 1'b1;
    end else if (in_run) begin
      if (spur_pending) begin spur_pending = 1'b0; spur_active = 1'b1; end
      else begin en_net = 1'b1; net_cnt = 4; end
    end
    nif.neuronWrQDone       = ld_flag[0];
    nif.neuronWrVmemDone    = ld_flag[1];
    nif.neuronWrNeuronIDone = ld_flag[2];
    nif.neuronWrMuDone      = ld_flag[3];
    nif.en_network          = en_net;
    nif.networkDone         = net_done_drv | spur_active;
  endtask

  task automatic write_tbl(input int a, input logic [15:0] d);
    sched_we = 1'b1; sched_addr = a[3:0]; sched_data = d;
    tick();
    sched_we = 1'b0;
    tbl_m[a] = d;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_status"}, {busy, done, timeout_err}, 3'b000);
    check({tag, "_strobes"}, {nif.en_neuron, nif.wrQ, nif.wrVmem, nif.wrNeuronI, nif.wrMu, nif.en_spike}, 6'd0);
    check({tag, "_iter"}, iter_count, 16'd0);
    check({tag, "_idx"}, sched_idx, 4'd0);
  endtask

  task automatic clear_model();
    strobe_log.delete(); mu_log.delete(); idx_log.delete(); it_log.delete();
    overlap = 0; spikes = 0; accepted = 0; fin_en = 1'b1; fin_done = 1'b0;
    en_net = 1'b0; net_done_drv = 1'b0; in_run = 1'b0;
  endtask

  task automatic run(input int n, input int spm, input bit poke);
    int c, budget, e;
    clear_model();
    num_iter = n[15:0]; steps_per_mu = spm[7:0];
    start = 1'b1; tick(); start = 1'b0;
    check("start_clears_done", done, 1'b0);
    check("start_clears_terr", timeout_err, 1'b0);
    check("load_busy", busy, 1'b1);
    check("load_en_neuron", nif.en_neuron, 1'b1);
    budget = 200 + 12 * n; c = 0;
    while (!(done === 1'b1 && busy === 1'b0) && c < budget) begin
      start    = poke && (c == 5);
      sched_we = poke && (c == 5);
      sched_addr = 4'd0; sched_data = ~tbl_m[0];
      tick(); c++;
    end
    start = 1'b0; sched_we = 1'b0;
    check("run_completes", c < budget, 1'b1);
    check("strobe_count", strobe_log.size(), 4);
    for (int i = 0; i < 4; i++) check("strobe_order", strobe_log[i], i);
    check("strobe_overlap", overlap, 0);
    check("spike_pulses", spikes, (n != 0) ? 1 : 0);
    check("iter_accepted", accepted, n);
    check("iter_count_final", iter_count, n[15:0]);
    for (int k = 1; k <= accepted; k++) begin
      e = k / ((spm == 0) ? 1 : spm);
      if (e > 15) e = 15;
      check("mu_sched", mu_log[k-1], tbl_m[e]);
      check("sched_idx", idx_log[k-1], e[3:0]);
      check("iter_step", it_log[k-1], k[15:0]);
    end
    if (n != 0) begin
      check("en_neuron_drop", fin_en, 1'b0);
      check("done_after_last", fin_done, 1'b1);
    end
    check("done_final", done, 1'b1);
    check("en_neuron_final", nif.en_neuron, 1'b0);
    tick();
  endtask

  initial begin
    int c;
    reset = 1'b1; start = 1'b0; sched_we = 1'b0; sched_addr = 4'd0; sched_data = 16'd0;
    num_iter = 16'd0; steps_per_mu = 8'd0;
    for (int i = 0; i < 4; i++) begin ld_cnt[i] = 0; ld_flag[i] = 1'b0; end
    nif.neuronWrQDone = 1'b0; nif.neuronWrVmemDone = 1'b0; nif.neuronWrNeuronIDone = 1'b0;
    nif.neuronWrMuDone = 1'b0; nif.en_network = 1'b0; nif.networkDone = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);

    // Directed load-and-run with the reference schedule.
    write_tbl(0, 16'h3C00); write_tbl(1, 16'h3800);
    write_tbl(2, 16'h3400); write_tbl(3, 16'h3000);
    for (int i = 4; i < 16; i++) write_tbl(i, 16'($urandom));
    run(5, 2, 1'b0);
    for (int i = 0; i < 5; i++) check("mu_vector", mu_log[i], exp33[i]);

    run(0, 3, 1'b0);
    run(20, 1, 1'b0);

    // Load watchdog: vmem done never arrives.
    clear_model();
    hold_vmem_low = 1'b1; num_iter = 16'd2; steps_per_mu = 8'd1;
    start = 1'b1; tick(); start = 1'b0;
    c = 0;
    while (nif.wrVmem !== 1'b1 && c < 50) begin tick(); c++; end
    check("vmem_strobe_seen", nif.wrVmem, 1'b1);
    c = cyc;
    while (timeout_err !== 1'b1 && (cyc - c) < TMO + 20) tick();
    check("tmo_latency", cyc - c, TMO);
    check("tmo_en_neuron", nif.en_neuron, 1'b0);
    check("tmo_done", done, 1'b1);
    repeat (3) tick();
    check("tmo_held", {timeout_err, done, busy}, 3'b110);
    hold_vmem_low = 1'b0;
    run(2, 1, 1'b0);

    // Reset in the middle of RUN.
    clear_model();
    num_iter = 16'd10; steps_per_mu = 8'd2;
    start = 1'b1; tick(); start = 1'b0;
    c = 0;
    while (iter_count !== 16'd3 && c < 400) begin tick(); c++; end
    check("reached_iter3", iter_count, 16'd3);
    reset = 1'b1; tick();
    check_reset_state("mid_run_reset");
    reset = 1'b0; clear_model();
    reset = 1'b1; start = 1'b1; tick();
    start = 1'b0; reset = 1'b0; tick();
    check("reset_beats_start", {busy, nif.en_neuron}, 2'b00);

    // Start and table write while busy, plus a networkDone without en_network.
    spur_pending = 1'b1;
    run(3, 2, 1'b1);

    // Randomized runs against the schedule model.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) write_tbl(i, 16'($urandom));
      run($urandom_range(1, 40), (r == 0) ? 0 : $urandom_range(1, 4), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/anneal_ctrl.md
ANNEAL_CTRL -- requirements
Module: anneal_ctrl

Interface
REQ-001 Parameters SHALL be: FP_DATA_WIDTH, default 16, mu word width; ITER_WIDTH, default 16, iteration count width; TIMEOUT, default 1024, load-handshake watchdog limit in cycles.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle run request.
REQ-005 num_iter  in  ITER_WIDTH  number of spike/network iterations to run.
REQ-006 steps_per_mu  in  8  iterations per mu schedule step.
REQ-007 sched_we / sched_addr / sched_data  in  1 / 4 / FP_DATA_WIDTH  mu schedule table write port (16 entries).
REQ-008 neuronWrQDone, neuronWrVmemDone, neuronWrNeuronIDone, neuronWrMuDone  in  1 each  neuron load-done flags.
REQ-009 en_network, networkDone  in  1 each  neuron network-phase request and network completion.
REQ-010 en_neuron, wrQ, wrVmem, wrNeuronI, wrMu, en_spike  out  1 each  neuron enable and command strobes.
REQ-011 mu_sched  out  FP_DATA_WIDTH  drives the neuron mu_in.
REQ-012 busy, done, timeout_err  out  1 each  status; iter_count  out  ITER_WIDTH; sched_idx  out  4.

Function
REQ-013 FSM states SHALL be IDLE, LD_Q, LD_VMEM, LD_NID, LD_MU, SPIKE, RUN, FINISH, ERR.
REQ-014 IDLE: start=1 SHALL clear done, timeout_err, iter_count and sched_idx, and enter LD_Q; start is ignored in every other state.
REQ-015 Each LD_x state SHALL pulse its strobe (wrQ, wrVmem, wrNeuronI or wrMu) for exactly one cycle on entry, then wait.
REQ-016 An LD_x state SHALL advance only when its done flag is 1 and at least 2 cycles have passed since the strobe.
REQ-017 Load order SHALL be LD_Q -> LD_VMEM -> LD_NID -> LD_MU -> SPIKE, with no two strobes asserted in the same cycle.
REQ-018 A per-state wait counter SHALL reach TIMEOUT without the done flag -> ERR; timeout_err=1, done=1, en_neuron=0, all held until the next start.
REQ-019 en_neuron SHALL be 1 in all LD_x, SPIKE and RUN states, and 0 in IDLE, FINISH and ERR.
REQ-020 SPIKE: if num_iter=0 -> FINISH with no en_spike; otherwise pulse en_spike for one cycle -> RUN.
REQ-021 RUN: an iteration completes on a cycle with en_network=1 and networkDone=1; iter_count SHALL increment (+1) on that cycle.
REQ-022 networkDone while en_network=0 SHALL be ignored.
REQ-023 RUN: when the incremented iter_count equals num_iter -> FINISH on the next cycle, so en_neuron drops 1 cycle after the final networkDone.
REQ-024 sched_idx SHALL equal min(floor(iter_count / max(steps_per_mu,1)), 15); steps_per_mu=0 is treated as 1; sched_idx saturates at 15, no wrap.
REQ-025 mu_sched SHALL equal table[sched_idx] combinationally in every state, so the neuron latches the next-iteration mu on the same cycle as networkDone.
REQ-026 FINISH: done=1 -> IDLE; done SHALL hold 1 until the next accepted start.
REQ-027 busy SHALL be 1 in every state except IDLE and FINISH; busy is 0 in FINISH.
REQ-028 Table writes SHALL take effect when busy=0; writes while busy=1 SHALL be dropped.
REQ-029 Table contents SHALL persist across runs; the table is not cleared by reset.

Reset
REQ-030 reset=1 SHALL force IDLE on the next edge from any state, including mid-load and mid-RUN.
REQ-031 On reset, all strobes, en_neuron, busy, done and timeout_err SHALL be 0, and iter_count=0, sched_idx=0, wait counter=0.
REQ-032 reset SHALL take priority over start in the same cycle.

Verification
REQ-033 Load and run: table[0..3]=0x3C00,0x3800,0x3400,0x3000, steps_per_mu=2, num_iter=5, neuron model with done flags after 3 cycles and networkDone 4 cycles after en_network -> strobes in order wrQ, wrVmem, wrNeuronI, wrMu; mu_sched on networkDone #1..#5 = 0x3C00,0x3800,0x3800,0x3400,0x3400; done=1, iter_count=5, en_neuron=0 one cycle after the 5th networkDone.
REQ-034 num_iter=0 -> full load sequence, no en_spike, done=1, iter_count=0.
REQ-035 steps_per_mu=1, num_iter=20 -> sched_idx reaches 15 at iteration 15 and stays 15 through 20.
REQ-036 neuronWrVmemDone held 0 -> ERR after TIMEOUT cycles in LD_VMEM; timeout_err=1, en_neuron=0; a new start clears both flags.
REQ-037 reset asserted in RUN with iter_count=3 -> next cycle IDLE, all outputs at reset values; start during busy and sched_we during busy have no effect; networkDone with en_network=0 does not count.
